// File: rtl/printer_alarm_annunciator_pkg.sv
// Shared definitions for the printer alarm annunciator.
// Holds the per-channel acknowledge state encoding and the next-state function
// used by every alarm channel.
package printer_alarm_annunciator_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'b00,
        ST_UNACK     = 2'b01,
        ST_ACKED     = 2'b10,
        ST_RTN_UNACK = 2'b11
    } chan_state_t;

    // Acknowledge state machine transition. q is the qualified alarm level.
    // Re-assertion from RTN_UNACK wins over a simultaneous ack.
    function automatic chan_state_t chan_next(input chan_state_t s,
                                              input logic        q,
                                              input logic        ack);
        chan_state_t n;
        n = ST_NORMAL;
        case (s)
            ST_NORMAL:    n = q ? ST_UNACK : ST_NORMAL;
            ST_UNACK: begin
                if (q)        n = ack ? ST_ACKED  : ST_UNACK;
                else          n = ack ? ST_NORMAL : ST_RTN_UNACK;
            end
            ST_ACKED:     n = q ? ST_ACKED : ST_NORMAL;
            ST_RTN_UNACK: begin
                if (q)        n = ST_UNACK;
                else if (ack) n = ST_NORMAL;
                else          n = ST_RTN_UNACK;
            end
            default:      n = ST_NORMAL;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: glitch filter, qualified level register, acknowledge FSM
// and lamp decode.
//
// state        | meaning
// -------------+------------------------------------------------
// ST_NORMAL    | no alarm, lamp off
// ST_UNACK     | alarm active, not acknowledged, lamp blinks
// ST_ACKED     | alarm active, acknowledged, lamp steady on
// ST_RTN_UNACK | alarm cleared before ack, lamp blinks, silent
//
// Ports:
//   clk, rst      clock / async active-high reset
//   raw           raw alarm request
//   ack           operator acknowledge (level)
//   phase         blink phase from the top level
//   led           lamp drive
//   unack         channel is in ST_UNACK (feeds the buzzer)
//   pending       channel is not ST_NORMAL
module alarm_channel
    import printer_alarm_annunciator_pkg::*;
#(
    parameter int FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic ack,
    input  logic phase,
    output logic led,
    output logic unack,
    output logic pending
);

    localparam int            CW       = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;
    chan_state_t   state_q, state_d;

    // Any cycle where raw agrees with q restarts the qualification window,
    // so only FILT consecutive disagreeing cycles move q.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (raw == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            q_d   = raw;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign state_d = chan_next(state_q, q_q, ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            q_q     <= 1'b0;
            state_q <= ST_NORMAL;
        end else begin
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        led = 1'b0;
        case (state_q)
            ST_NORMAL:    led = 1'b0;
            ST_ACKED:     led = 1'b1;
            ST_UNACK:     led = phase;
            ST_RTN_UNACK: led = phase;
            default:      led = 1'b0;
        endcase
    end

    assign unack   = (state_q == ST_UNACK);
    assign pending = (state_q != ST_NORMAL);

endmodule

// File: rtl/printer_alarm_annunciator.sv
// Operator-facing alarm annunciator: three filtered/acknowledged alarm
// channels, a free-running blink generator and the buzzer/pending logic.
//
// Ports:
//   clk, rst                 clock / async active-high reset
//   A, B, C                  raw alarm requests (C = multiple faults)
//   ack                      operator acknowledge (level)
//   led_a, led_b, led_c      alarm lamps
//   buzzer                   audible alarm (steady for C, blinking for A/B)
//   alarm_pending            any channel not NORMAL
module printer_alarm_annunciator
    import printer_alarm_annunciator_pkg::*;
#(
    parameter int FILT      = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic ack,
    output logic led_a,
    output logic led_b,
    output logic led_c,
    output logic buzzer,
    output logic alarm_pending
);

    localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic          unack_a, unack_b, unack_c;
    logic          pend_a, pend_b, pend_c;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_END) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    alarm_channel #(.FILT(FILT)) u_ch_a (
        .clk(clk), .rst(rst), .raw(A), .ack(ack), .phase(phase_q),
        .led(led_a), .unack(unack_a), .pending(pend_a)
    );

    alarm_channel #(.FILT(FILT)) u_ch_b (
        .clk(clk), .rst(rst), .raw(B), .ack(ack), .phase(phase_q),
        .led(led_b), .unack(unack_b), .pending(pend_b)
    );

    alarm_channel #(.FILT(FILT)) u_ch_c (
        .clk(clk), .rst(rst), .raw(C), .ack(ack), .phase(phase_q),
        .led(led_c), .unack(unack_c), .pending(pend_c)
    );

    // C overrides with a continuous tone; RTN_UNACK is intentionally silent.
    assign buzzer        = unack_c | ((unack_a | unack_b) & phase_q);
    assign alarm_pending = pend_a | pend_b | pend_c;

endmodule

// File: tb/tb_printer_alarm_annunciator.sv
// Directed bench for printer_alarm_annunciator with FILT=4, BLINK_DIV=2.
// Each table row holds the inputs applied before one rising edge and the
// expected outputs after it. Output code 2 means "equals blink phase", where
// the phase after edge n since reset release is bit 1 of n.
module tb_printer_alarm_annunciator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0, ack = 1'b0;
    logic led_a, led_b, led_c, buzzer, alarm_pending;

    always #5 clk = ~clk;

    printer_alarm_annunciator #(.FILT(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .ack(ack),
        .led_a(led_a), .led_b(led_b), .led_c(led_c),
        .buzzer(buzzer), .alarm_pending(alarm_pending)
    );

    typedef struct {
        logic       r, a, b, c, k;
        logic [1:0] la, lb, lc, bz, pd;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [1:0] P = 2'd2;

    task automatic add(input int cnt, input logic r, a, b, c, k,
                       input logic [1:0] la, lb, lc, bz, pd);
        vec_t v;
        v.r = r; v.a = a; v.b = b; v.c = c; v.k = k;
        v.la = la; v.lb = lb; v.lc = lc; v.bz = bz; v.pd = pd;
        repeat (cnt) vecs.push_back(v);
    endtask

    function automatic logic ph(input int n);
        return ((n / 2) % 2) == 1;
    endfunction

    function automatic logic res(input logic [1:0] code, input int n);
        return (code == P) ? ph(n) : code[0];
    endfunction

    task automatic check_row(input int idx, input int n, input vec_t v);
        logic [4:0] got, exp;
        got = {led_a, led_b, led_c, buzzer, alarm_pending};
        exp = {res(v.la, n), res(v.lb, n), res(v.lc, n), res(v.bz, n), res(v.pd, n)};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row %0d edge %0d: {led_a,led_b,led_c,buzzer,pending} got %b expected %b",
                     idx, n, got, exp);
        end
    endtask

    initial begin
        int n;
        int edges;

        // Reset with all alarms high, then held through release (C priority).
        add(1, 1, 1,1,1,0, 0,0,0,0,0);
        add(4, 0, 1,1,1,0, 0,0,0,0,0);
        add(3, 0, 1,1,1,0, P,P,P,1,1);
        add(1, 0, 1,1,1,1, 1,1,1,0,1);
        add(1, 0, 1,1,1,0, 1,1,1,0,1);
        add(4, 0, 0,0,0,0, 1,1,1,0,1);
        add(1, 0, 0,0,0,0, 0,0,0,0,0);
        // Glitch rejection, then ack flow on A.
        add(1, 1, 0,0,0,0, 0,0,0,0,0);
        add(3, 0, 1,0,0,0, 0,0,0,0,0);
        add(4, 0, 0,0,0,0, 0,0,0,0,0);
        add(4, 0, 1,0,0,0, 0,0,0,0,0);
        add(1, 0, 1,0,0,0, P,0,0,P,1);
        add(1, 0, 1,0,0,1, 1,0,0,0,1);
        add(1, 0, 1,0,0,0, 1,0,0,0,1);
        add(4, 0, 0,0,0,0, 1,0,0,0,1);
        add(1, 0, 0,0,0,0, 0,0,0,0,0);
        // Return before ack on B.
        add(1, 1, 0,0,0,0, 0,0,0,0,0);
        add(4, 0, 0,1,0,0, 0,0,0,0,0);
        add(1, 0, 0,1,0,0, 0,P,0,P,1);
        add(4, 0, 0,0,0,0, 0,P,0,P,1);
        add(2, 0, 0,0,0,0, 0,P,0,0,1);
        add(1, 0, 0,0,0,1, 0,0,0,0,0);
        // Re-assert race: q returns high while ack is applied in RTN_UNACK.
        add(1, 1, 0,0,0,0, 0,0,0,0,0);
        add(4, 0, 0,1,0,0, 0,0,0,0,0);
        add(1, 0, 0,1,0,0, 0,P,0,P,1);
        add(4, 0, 0,0,0,0, 0,P,0,P,1);
        add(1, 0, 0,0,0,0, 0,P,0,0,1);
        add(4, 0, 0,1,0,0, 0,P,0,0,1);
        add(1, 0, 0,1,0,1, 0,P,0,P,1);
        add(1, 0, 0,1,0,0, 0,P,0,P,1);
        // Mid-operation reset; held ack does not pre-acknowledge.
        add(1, 1, 1,0,0,1, 0,0,0,0,0);
        add(4, 0, 1,0,0,1, 0,0,0,0,0);
        add(1, 0, 1,0,0,1, P,0,0,P,1);
        add(1, 0, 1,0,0,1, 1,0,0,0,1);
        add(1, 0, 1,0,0,0, 1,0,0,0,1);
        // UNACK with q low and ack goes straight to NORMAL.
        add(1, 1, 0,0,0,0, 0,0,0,0,0);
        add(4, 0, 1,0,0,0, 0,0,0,0,0);
        add(1, 0, 1,0,0,0, P,0,0,P,1);
        add(4, 0, 0,0,0,0, P,0,0,P,1);
        add(1, 0, 0,0,0,1, 0,0,0,0,0);

        n = 0;
        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            A = vecs[i].a; B = vecs[i].b; C = vecs[i].c; ack = vecs[i].k;
            if (vecs[i].r) begin
                rst = 1'b1;
                #1;
                check_row(i, 0, vecs[i]);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                n = 0;
            end else begin
                @(posedge clk);
                #1;
                n++;
                check_row(i, n, vecs[i]);
                @(negedge clk);
            end
        end

        // Bounded wait for C to qualify after a reset release.
        A = 1'b0; B = 1'b0; C = 1'b1; ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        edges = 0;
        while (!alarm_pending && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (edges != 5) begin
            errors++;
            $display("FAIL c_latency: pending after %0d edges, expected 5", edges);
        end
        checks++;
        if (buzzer !== 1'b1) begin
            errors++;
            $display("FAIL c_buzzer: got %b expected 1", buzzer);
        end
        checks++;
        if (led_c !== 1'b0) begin
            errors++;
            $display("FAIL c_led_phase: got %b expected 0", led_c);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (led_c !== 1'b1 || buzzer !== 1'b1) begin
            errors++;
            $display("FAIL c_blink: led_c=%b buzzer=%b expected led_c=1 buzzer=1", led_c, buzzer);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
